// File: rtl/match_ctrl.sv
// Pong game-flow controller: sequences a match and drives the score block
// and ball/physics control inputs. All outputs come straight from flops.
module match_ctrl #(
    parameter int SERVE_DELAY   = 60,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       frame_tick,
    input  logic       ball_out_left,
    input  logic       ball_out_right,
    input  logic       win1,
    input  logic       win2,
    output logic       score_clear,
    output logic       p1_scored,
    output logic       p2_scored,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LAST  = 8'(SERVE_DELAY - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic       score_clear_q, score_clear_d;
    logic       p1_scored_q, p1_scored_d;
    logic       p2_scored_q, p2_scored_d;
    logic       ball_reset_q, ball_reset_d;
    logic       ball_enable_q, ball_enable_d;
    logic       serve_dir_q, serve_dir_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;

    always_comb begin
        state_d       = state_q;
        serve_cnt_d   = '0;
        settle_cnt_d  = '0;
        score_clear_d = 1'b0;
        p1_scored_d   = 1'b0;
        p2_scored_d   = 1'b0;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    score_clear_d = 1'b1;
                    serve_dir_d   = 1'b0;
                    state_d       = SERVE;
                end
            end
            SERVE: begin
                serve_cnt_d = serve_cnt_q;
                if (frame_tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                // Simultaneous exits on both sides are a dead ball: re-serve.
                if (ball_out_left && ball_out_right) begin
                    state_d = SERVE;
                end else if (ball_out_left) begin
                    p2_scored_d = 1'b1;
                    serve_dir_d = 1'b1;
                    state_d     = POINT;
                end else if (ball_out_right) begin
                    p1_scored_d = 1'b1;
                    serve_dir_d = 1'b0;
                    state_d     = POINT;
                end else if (pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause) begin
                    state_d = PLAY;
                end
            end
            POINT: begin
                // Give the score block time to register the point before
                // trusting its win flags.
                if (settle_cnt_q == SETTLE_LAST) begin
                    if (win1) begin
                        winner_d = 1'b0;
                        state_d  = GAME_OVER;
                    end else if (win2) begin
                        winner_d = 1'b1;
                        state_d  = GAME_OVER;
                    end else begin
                        state_d = SERVE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    score_clear_d = 1'b1;
                    serve_dir_d   = 1'b0;
                    state_d       = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase

        ball_reset_d  = (state_d == IDLE) || (state_d == SERVE) ||
                        (state_d == POINT) || (state_d == GAME_OVER);
        ball_enable_d = (state_d == PLAY);
        game_over_d   = (state_d == GAME_OVER);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            serve_cnt_q   <= '0;
            settle_cnt_q  <= '0;
            score_clear_q <= 1'b0;
            p1_scored_q   <= 1'b0;
            p2_scored_q   <= 1'b0;
            ball_reset_q  <= 1'b1;
            ball_enable_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            serve_cnt_q   <= serve_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            score_clear_q <= score_clear_d;
            p1_scored_q   <= p1_scored_d;
            p2_scored_q   <= p2_scored_d;
            ball_reset_q  <= ball_reset_d;
            ball_enable_q <= ball_enable_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign score_clear = score_clear_q;
    assign p1_scored   = p1_scored_q;
    assign p2_scored   = p2_scored_q;
    assign ball_reset  = ball_reset_q;
    assign ball_enable = ball_enable_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: expected output words are queued as each
// step is driven and popped/compared one clock later.
module tb_match_ctrl;

    localparam int SD = 4;
    localparam int ST = 3;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSED = 3'd3, S_POINT = 3'd4, S_GO = 3'd5;

    logic       clock = 1'b0;
    logic       reset, start, pause, frame_tick, ball_out_left, ball_out_right;
    logic       win1, win2;
    logic       score_clear, p1_scored, p2_scored, ball_reset, ball_enable;
    logic       serve_dir, game_over, winner;
    logic [2:0] state;

    logic [7:0] p1_cnt, p2_cnt;
    logic       win1_force;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    match_ctrl #(.SERVE_DELAY(SD), .SETTLE_CYCLES(ST)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .frame_tick(frame_tick), .ball_out_left(ball_out_left),
        .ball_out_right(ball_out_right), .win1(win1), .win2(win2),
        .score_clear(score_clear), .p1_scored(p1_scored), .p2_scored(p2_scored),
        .ball_reset(ball_reset), .ball_enable(ball_enable), .serve_dir(serve_dir),
        .game_over(game_over), .winner(winner), .state(state)
    );

    always #5 clock = ~clock;

    // Score/win block model: first to 10 points wins.
    always @(posedge clock) begin
        if (!reset || score_clear) begin
            p1_cnt <= 8'd0;
            p2_cnt <= 8'd0;
        end else begin
            if (p1_scored) p1_cnt <= p1_cnt + 8'd1;
            if (p2_scored) p2_cnt <= p2_cnt + 8'd1;
        end
    end
    assign win1 = (p1_cnt >= 8'd10) || win1_force;
    assign win2 = (p2_cnt >= 8'd10);

    wire [10:0] obs = {state, score_clear, p1_scored, p2_scored, ball_reset,
                       ball_enable, serve_dir, game_over, winner};

    function automatic logic [10:0] ex(input logic [2:0] st, input logic sc,
                                       input logic p1, input logic p2,
                                       input logic sd, input logic w);
        logic br, be, go;
        br = (st == S_IDLE) || (st == S_SERVE) || (st == S_POINT) || (st == S_GO);
        be = (st == S_PLAY);
        go = (st == S_GO);
        return {st, sc, p1, p2, br, be, sd, go, w};
    endfunction

    task automatic step(input string tag, input logic [10:0] e);
        exp_t x;
        sb.push_back('{v: e, tag: tag});
        @(posedge clock);
        #1;
        x = sb.pop_front();
        checks++;
        assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", x.tag, obs, x.v);
        end
        $display("step %-14s state=%0d out=%b", x.tag, state, obs);
        start = 0; pause = 0; frame_tick = 0;
        ball_out_left = 0; ball_out_right = 0;
    endtask

    task automatic serve_run(input logic sd, input logic w);
        for (int i = 1; i <= SD; i++) begin
            frame_tick = 1;
            step($sformatf("serve_tick%0d", i),
                 ex((i < SD) ? S_SERVE : S_PLAY, 0, 0, 0, sd, w));
        end
    endtask

    // Ball-out from PLAY, settle, then land in final_st.
    task automatic point_run(input logic left, input logic [2:0] final_st,
                             input logic w_prev, input logic w_fin);
        logic sd;
        sd = left;
        ball_out_left  = left;
        ball_out_right = !left;
        step("point_pulse", ex(S_POINT, 0, !left, left, sd, w_prev));
        for (int i = 1; i < ST; i++)
            step($sformatf("point_settle%0d", i), ex(S_POINT, 0, 0, 0, sd, w_prev));
        step("point_exit", ex(final_st, 0, 0, 0, sd, w_fin));
    endtask

    initial begin
        reset = 0; start = 0; pause = 0; frame_tick = 0;
        ball_out_left = 0; ball_out_right = 0; win1_force = 0;

        step("reset0", ex(S_IDLE, 0, 0, 0, 0, 0));
        step("reset1", ex(S_IDLE, 0, 0, 0, 0, 0));
        reset = 1;
        step("idle", ex(S_IDLE, 0, 0, 0, 0, 0));
        pause = 1; ball_out_left = 1;
        step("idle_ignore", ex(S_IDLE, 0, 0, 0, 0, 0));

        start = 1;
        step("start", ex(S_SERVE, 1, 0, 0, 0, 0));
        step("clear_end", ex(S_SERVE, 0, 0, 0, 0, 0));
        pause = 1;
        step("serve_pause", ex(S_SERVE, 0, 0, 0, 0, 0));
        start = 1; ball_out_right = 1;
        step("serve_ignore", ex(S_SERVE, 0, 0, 0, 0, 0));
        frame_tick = 1;
        step("serve_tick1", ex(S_SERVE, 0, 0, 0, 0, 0));
        step("serve_idle", ex(S_SERVE, 0, 0, 0, 0, 0));
        for (int i = 2; i <= SD; i++) begin
            frame_tick = 1;
            step("serve_tickn", ex((i < SD) ? S_SERVE : S_PLAY, 0, 0, 0, 0, 0));
        end
        start = 1;
        step("play_start", ex(S_PLAY, 0, 0, 0, 0, 0));

        point_run(1'b0, S_SERVE, 1'b0, 1'b0);
        serve_run(1'b0, 1'b0);

        pause = 1;
        step("pause_on", ex(S_PAUSED, 0, 0, 0, 0, 0));
        ball_out_left = 1;
        step("paused_out", ex(S_PAUSED, 0, 0, 0, 0, 0));
        pause = 1;
        step("pause_off", ex(S_PLAY, 0, 0, 0, 0, 0));

        pause = 1;
        point_run(1'b1, S_SERVE, 1'b0, 1'b0);
        serve_run(1'b1, 1'b0);
        ball_out_left = 1; ball_out_right = 1;
        step("both_out", ex(S_SERVE, 0, 0, 0, 1, 0));
        serve_run(1'b1, 1'b0);

        for (int n = 2; n <= 10; n++) begin
            point_run(1'b1, (n < 10) ? S_SERVE : S_GO, 1'b0, n == 10);
            if (n < 10) serve_run(1'b1, 1'b0);
        end
        step("go_hold", ex(S_GO, 0, 0, 0, 1, 1));
        pause = 1; ball_out_right = 1;
        step("go_ignore", ex(S_GO, 0, 0, 0, 1, 1));
        start = 1;
        step("restart", ex(S_SERVE, 1, 0, 0, 0, 1));
        step("restart_clr", ex(S_SERVE, 0, 0, 0, 0, 1));
        serve_run(1'b0, 1'b1);

        pause = 1;
        step("pause_on2", ex(S_PAUSED, 0, 0, 0, 0, 1));
        reset = 0; pause = 1;
        step("rst_paused", ex(S_IDLE, 0, 0, 0, 0, 0));
        reset = 1; start = 1;
        step("start2", ex(S_SERVE, 1, 0, 0, 0, 0));
        serve_run(1'b0, 1'b0);
        ball_out_right = 1;
        step("point_p1", ex(S_POINT, 0, 1, 0, 0, 0));
        reset = 0;
        step("rst_point", ex(S_IDLE, 0, 0, 0, 0, 0));
        reset = 1; start = 1;
        step("start3", ex(S_SERVE, 1, 0, 0, 0, 0));
        serve_run(1'b0, 1'b0);
        win1_force = 1;
        point_run(1'b0, S_GO, 1'b0, 1'b0);
        win1_force = 0;
        reset = 0; start = 1;
        step("rst_go", ex(S_IDLE, 0, 0, 0, 0, 0));
        reset = 1;
        step("idle_end", ex(S_IDLE, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
